// File: rtl/coeff_update_ctrl_if.sv
// coeff_update_ctrl_if: start/ready handshake and coefficient bus between coeff_update_ctrl and coefficient_unit
interface coeff_update_ctrl_if #(parameter int W = 24);
    logic                cu_start;
    logic [W-1:0]        cu_cutoff_freq;
    logic                cu_ready;
    logic signed [W-1:0] cu_b0, cu_b1, cu_b2, cu_a1, cu_a2;
    modport master (output cu_start, cu_cutoff_freq,
                    input  cu_ready, cu_b0, cu_b1, cu_b2, cu_a1, cu_a2);
    modport slave  (input  cu_start, cu_cutoff_freq,
                    output cu_ready, cu_b0, cu_b1, cu_b2, cu_a1, cu_a2);
endinterface

// File: rtl/coeff_update_ctrl.sv
// coeff_update_ctrl: rate-limited coefficient_unit sequencer with sample-aligned double-buffered coefficient swap
// Defining CTRL_TIMEOUT_EN adds a sticky watchdog on the WAIT state.
module coeff_update_ctrl #(
    parameter int SAMPLE_WIDTH   = 24,
    parameter int MIN_CUTOFF     = 69,
    parameter int MAX_CUTOFF     = 1024,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SAMPLE_WIDTH-1:0]        cutoff_in,
    input  logic                           sample_tick,
    coeff_update_ctrl_if.master            cu,
    output logic signed [SAMPLE_WIDTH-1:0] b0, b1, b2, a1, a2,
    output logic                           coeff_valid,
    output logic                           swap_pulse,
    output logic                           busy,
    output logic                           timeout_err
);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, ARMED = 2'd3;
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [SAMPLE_WIDTH-1:0] UNITY = SAMPLE_WIDTH'(65536);

    if (MIN_CUTOFF > MAX_CUTOFF || HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("coeff_update_ctrl: invalid parameters");
    end

    logic [1:0]                     state;
    logic [HW-1:0]                  holdoff;
    logic [SAMPLE_WIDTH-1:0]        clamped, last_req, restore_req;
    logic signed [SAMPLE_WIDTH-1:0] s_b0, s_b1, s_b2, s_a1, s_a2;
    logic                           first_wait, go, accept, timeout_hit;

    always_comb begin
        clamped = (cutoff_in < SAMPLE_WIDTH'(MIN_CUTOFF)) ? SAMPLE_WIDTH'(MIN_CUTOFF) :
                  (cutoff_in > SAMPLE_WIDTH'(MAX_CUTOFF)) ? SAMPLE_WIDTH'(MAX_CUTOFF) : cutoff_in;
        go      = state == IDLE && clamped != last_req && holdoff == '0;
        // first WAIT cycle masks a ready level left over from the previous run
        accept  = state == WAIT && !first_wait && cu.cu_ready;
    end

    assign busy = state != IDLE;

`ifdef CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0]           wait_cnt;
    logic [SAMPLE_WIDTH-1:0] prev_req;

    assign timeout_hit = state == WAIT && !accept && wait_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign restore_req = prev_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            prev_req    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (go) prev_req <= last_req;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign restore_req = last_req;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            holdoff           <= '0;
            last_req          <= '0;
            first_wait        <= 1'b0;
            cu.cu_start       <= 1'b0;
            cu.cu_cutoff_freq <= '0;
            {s_b0, s_b1, s_b2, s_a1, s_a2} <= '0;
            b0                <= UNITY;
            {b1, b2, a1, a2}  <= '0;
            coeff_valid       <= 1'b0;
            swap_pulse        <= 1'b0;
        end else begin
            cu.cu_start <= 1'b0;
            swap_pulse  <= 1'b0;
            holdoff     <= cu.cu_start ? HW'(HOLDOFF_CYCLES - 1) : (holdoff != '0) ? holdoff - 1'b1 : '0;
            if (state == IDLE) begin
                if (go) begin
                    state             <= START;
                    cu.cu_start       <= 1'b1;
                    cu.cu_cutoff_freq <= clamped;
                    last_req          <= clamped;
                end
            end else if (state == START) begin
                state      <= WAIT;
                first_wait <= 1'b1;
            end else if (state == WAIT) begin
                first_wait <= 1'b0;
                if (accept) begin
                    {s_b0, s_b1, s_b2, s_a1, s_a2} <= {cu.cu_b0, cu.cu_b1, cu.cu_b2, cu.cu_a1, cu.cu_a2};
                    state <= ARMED;
                end else if (timeout_hit) begin
                    state    <= IDLE;
                    last_req <= restore_req;
                end
            end else if (sample_tick) begin
                {b0, b1, b2, a1, a2} <= {s_b0, s_b1, s_b2, s_a1, s_a2};
                swap_pulse  <= 1'b1;
                coeff_valid <= 1'b1;
                state       <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_coeff_update_ctrl.sv
// tb_coeff_update_ctrl: directed table-driven bench for coeff_update_ctrl
module tb_coeff_update_ctrl;
    localparam int W = 24;
    typedef struct { int cutoff; bit exp_start; int exp_freq; } vec_t;

    logic                clk = 1'b0, reset = 1'b1, sample_tick = 1'b0;
    logic [W-1:0]        cutoff_in = '0;
    logic signed [W-1:0] b0, b1, b2, a1, a2;
    logic                coeff_valid, swap_pulse, busy, timeout_err;
    int                  passed = 0, total = 0, cyc = 0;
    int                  starts[$], start_cyc[$];
    logic signed [W-1:0] exp_c [5];
    vec_t                vecs [5];

    coeff_update_ctrl_if #(.W(W)) cu();

    coeff_update_ctrl #(
        .SAMPLE_WIDTH(W), .MIN_CUTOFF(69), .MAX_CUTOFF(1024),
        .HOLDOFF_CYCLES(256), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .cutoff_in(cutoff_in), .sample_tick(sample_tick), .cu(cu),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .coeff_valid(coeff_valid), .swap_pulse(swap_pulse), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // coefficient_unit stand-in: a distinct, easily recomputed set per cutoff
    function automatic logic signed [W-1:0] mc(input int f, input int k);
        int v;
        v = (k == 0) ? f * 3 : (k == 1) ? -f : (k == 2) ? f + 7 : (k == 3) ? -2 * f : 1000 - f;
        return W'(v);
    endfunction

    function automatic logic signed [W-1:0] got_c(input int k);
        return (k == 0) ? b0 : (k == 1) ? b1 : (k == 2) ? b2 : (k == 3) ? a1 : a2;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic chk_coeffs(input string name);
        for (int k = 0; k < 5; k++) chk(name, longint'(got_c(k)), longint'(exp_c[k]));
    endtask

    task automatic set_exp(input int f);
        for (int k = 0; k < 5; k++) exp_c[k] = mc(f, k);
    endtask

    task automatic set_reset_exp();
        exp_c[0] = W'(65536);
        for (int k = 1; k < 5; k++) exp_c[k] = '0;
    endtask

    task automatic present(input int f);
        cu.cu_b0 = mc(f, 0); cu.cu_b1 = mc(f, 1); cu.cu_b2 = mc(f, 2);
        cu.cu_a1 = mc(f, 3); cu.cu_a2 = mc(f, 4);
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (cu.cu_start) begin
            starts.push_back(int'(cu.cu_cutoff_freq));
            start_cyc.push_back(cyc);
        end
    endtask

    task automatic wait_start(input int lim, output bit got);
        int n0;
        n0 = starts.size();
        got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            step();
            if (starts.size() > n0) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_reset(input string name);
        set_reset_exp();
        chk_coeffs(name);
        chk({name, "_valid"}, coeff_valid, 0);
        chk({name, "_swap"}, swap_pulse, 0);
        chk({name, "_start"}, cu.cu_start, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_freq"}, cu.cu_cutoff_freq, 0);
    endtask

    initial begin
        bit g;
        int n0, seen, cd;
        vecs[0] = '{500, 1'b1, 500};
        vecs[1] = '{10, 1'b1, 69};
        vecs[2] = '{5000, 1'b1, 1024};
        vecs[3] = '{2000, 1'b0, 0};
        vecs[4] = '{70, 1'b1, 70};
        cu.cu_ready = 1'b0;
        present(0);

        repeat (3) step();
        check_reset("reset");
        chk("reset_terr", timeout_err, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            cutoff_in = W'(vecs[i].cutoff);
            wait_start(300, g);
            chk("start_seen", g, vecs[i].exp_start);
            if (g) begin
                chk("start_freq", cu.cu_cutoff_freq, vecs[i].exp_freq);
                step();
                chk("start_one_cycle", cu.cu_start, 0);
                repeat (19) step();
                present(vecs[i].exp_freq);
                cu.cu_ready = 1'b1;
                step();
                cu.cu_ready = 1'b0;
                chk("armed_busy", busy, 1);
                chk_coeffs("held_before_tick");
                repeat (3) step();
                chk("no_early_swap", swap_pulse, 0);
                sample_tick = 1'b1;
                step();
                sample_tick = 1'b0;
                set_exp(vecs[i].exp_freq);
                chk("swap_pulse", swap_pulse, 1);
                chk_coeffs("swapped");
                chk("valid", coeff_valid, 1);
                step();
                chk("swap_one_cycle", swap_pulse, 0);
                chk("back_idle", busy, 0);
            end
        end

        // 100 -> 200 -> 300 inside the holdoff window: only 100 and 300 run
        repeat (300) step();
        n0 = starts.size();
        seen = n0;
        cd = 0;
        cutoff_in = 100;
        for (int i = 0; i < 700; i++) begin
            if (i == 20) cutoff_in = 200;
            if (i == 45) cutoff_in = 300;
            sample_tick = (i % 40 == 39);
            step();
            cu.cu_ready = 1'b0;
            if (starts.size() > seen) begin
                seen = starts.size();
                cd = 20;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    present(starts[$]);
                    cu.cu_ready = 1'b1;
                end
            end
        end
        sample_tick = 1'b0;
        cu.cu_ready = 1'b0;
        chk("holdoff_starts", starts.size() - n0, 2);
        if (starts.size() >= n0 + 2) begin
            chk("holdoff_first", starts[n0], 100);
            chk("holdoff_second", starts[n0 + 1], 300);
            chk("holdoff_spacing", (start_cyc[n0 + 1] - start_cyc[n0]) >= 256, 1);
        end
        set_exp(300);
        chk_coeffs("holdoff_final");

        // stale ready level plus a tick in the capture cycle
        repeat (300) step();
        present(111);
        cu.cu_ready = 1'b1;
        cutoff_in = 400;
        wait_start(300, g);
        chk("stale_start", g, 1);
        step();
        step();
        present(400);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        cu.cu_ready = 1'b0;
        chk("capture_tick_no_swap", swap_pulse, 0);
        chk("capture_armed", busy, 1);
        chk_coeffs("capture_held");
        repeat (2) step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        set_exp(400);
        chk("late_tick_swap", swap_pulse, 1);
        chk_coeffs("fresh_not_stale");

        // reset in WAIT, then in ARMED
        repeat (300) step();
        cutoff_in = 600;
        wait_start(300, g);
        repeat (3) step();
        chk("wait_busy", busy, 1);
        reset = 1'b1;
        step();
        check_reset("rst_wait");
        reset = 1'b0;
        wait_start(10, g);
        chk("rst_restart", g, 1);
        repeat (20) step();
        present(600);
        cu.cu_ready = 1'b1;
        step();
        cu.cu_ready = 1'b0;
        chk("armed_busy2", busy, 1);
        reset = 1'b1;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_reset("rst_armed");

`ifdef CTRL_TIMEOUT_EN
        cutoff_in = 800;
        reset = 1'b0;
        wait_start(10, g);
        chk("to_start", g, 1);
        n0 = start_cyc[$];
        cd = 0;
        while (!timeout_err && cd < 200) begin
            step();
            cd++;
        end
        chk("to_cycles", cd, 65);
        chk("to_idle", busy, 0);
        set_reset_exp();
        chk_coeffs("to_coeffs");
        chk("to_valid", coeff_valid, 0);
        wait_start(400, g);
        chk("to_retry", g, 1);
        chk("to_retry_freq", cu.cu_cutoff_freq, 800);
        chk("to_retry_spacing", (start_cyc[$] - n0) >= 256, 1);
        chk("to_sticky", timeout_err, 1);
`else
        chk("no_timeout", timeout_err, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
